// File: rtl/trotrig_mc.sv
`default_nettype none
// ============================================================================
// Module   : trotrig_mc
// Brief    : Multi-channel saturating-accumulator trigger with ANY/ALL/SEQ arming.
// Revision : 1.0 - initial release
// ============================================================================
module trotrig_mc #(
    parameter int NCHAN     = 4,
    parameter int DINBITS   = 8,
    parameter int COUNTBITS = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [NCHAN-1:0]         enable,
    input  logic [NCHAN*DINBITS-1:0] din,
    input  logic [1:0]               mode,
    output logic [NCHAN-1:0]         hit,
    output logic [2:0]               seq_ptr,
    output logic                     trigger,
    output logic                     trig_pulse
);

    localparam logic [31:0] c_THRESH   = 32'd1 << (DINBITS + COUNTBITS);
    localparam logic [32:0] c_INC      = 33'd1 << DINBITS;
    localparam logic [1:0]  c_MODE_ALL = 2'd1;
    localparam logic [1:0]  c_MODE_SEQ = 2'd2;
    localparam logic [3:0]  c_NCHAN    = 4'(NCHAN);
    localparam logic [2:0]  c_LASTCH   = 3'(NCHAN - 1);

    typedef enum logic [0:0] {
        ST_ARMED = 1'b0,
        ST_FIRED = 1'b1
    } state_t;

    function automatic logic [31:0] scramble(input logic [31:0] v);
        logic [31:0] t;
        t        = v;
        t[15:8]  = t[15:8] ^ t[7:0];
        t[31:16] = t[31:16] ^ t[15:0];
        return t;
    endfunction

    function automatic logic [31:0] descramble(input logic [31:0] s);
        logic [31:0] t;
        t        = s;
        t[31:16] = t[31:16] ^ t[15:0];
        t[15:8]  = t[15:8] ^ t[7:0];
        return t;
    endfunction

    logic [NCHAN-1:0][31:0] r_s;
    logic [NCHAN-1:0]       r_hit;
    logic [2:0]             r_seq_ptr;
    logic                   r_trigger;
    logic                   r_pulse;
    logic [1:0]             r_mode;
    state_t                 r_state;

    logic [NCHAN-1:0][31:0] w_vn;
    logic [NCHAN-1:0][31:0] w_s_n;
    logic [NCHAN-1:0]       w_hit_n;
    logic [NCHAN-1:0]       w_cross;
    logic [NCHAN-1:0]       w_run_mask;
    logic [3:0]             w_run;
    logic [3:0]             w_ptr_sum;
    logic                   w_stop;
    logic                   w_stray;
    logic                   w_fire;
    logic                   w_disarm;
    logic [2:0]             w_ptr_n;
    state_t                 w_state_n;

    // Only the scrambled word is stored; the true count exists purely in logic.
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        logic [31:0] w_v;
        logic [32:0] w_sum;
        assign w_v         = descramble(r_s[gi]);
        assign w_sum       = {1'b0, w_v}
                           + {{(33-DINBITS){1'b0}}, din[gi*DINBITS +: DINBITS]}
                           + c_INC;
        assign w_vn[gi]    = !enable[gi] ? w_v : (w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0]);
        assign w_hit_n[gi] = w_vn[gi] > c_THRESH;
        assign w_s_n[gi]   = scramble(w_vn[gi]);
    end

    assign w_cross = w_hit_n & ~r_hit;

    // Length of the contiguous run of crossings starting at the expected channel.
    always_comb begin
        w_run      = '0;
        w_run_mask = '0;
        w_stop     = 1'b0;
        for (int k = 0; k < NCHAN; k++) begin
            if (!w_stop && (4'(k) >= {1'b0, r_seq_ptr})) begin
                if (w_cross[k]) begin
                    w_run         = w_run + 4'd1;
                    w_run_mask[k] = 1'b1;
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
        w_ptr_sum = {1'b0, r_seq_ptr} + w_run;
        w_stray   = |(w_cross & ~w_run_mask);
    end

    always_comb begin
        w_state_n = r_state;
        w_fire    = 1'b0;
        w_disarm  = 1'b0;
        w_ptr_n   = r_seq_ptr;
        if (r_state == ST_ARMED) begin
            case (r_mode)
                c_MODE_ALL: begin
                    if (&w_hit_n) w_fire = 1'b1;
                end
                c_MODE_SEQ: begin
                    if (w_stray) begin
                        w_disarm = 1'b1;
                    end else if (w_run != 4'd0) begin
                        if (w_ptr_sum == c_NCHAN) begin
                            w_fire  = 1'b1;
                            w_ptr_n = c_LASTCH;
                        end else begin
                            w_ptr_n = w_ptr_sum[2:0];
                        end
                    end
                end
                default: begin
                    if (|w_hit_n) w_fire = 1'b1;
                end
            endcase
        end
        if (w_fire) w_state_n = ST_FIRED;
    end

    always_ff @(posedge clk) begin
        if (reset || clear || w_disarm) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_s       <= '0;
            r_hit     <= '0;
            r_seq_ptr <= '0;
            r_trigger <= 1'b0;
            r_pulse   <= 1'b0;
            r_mode    <= mode;
        end else if (w_disarm) begin
            // Out-of-order crossing behaves as a clear that keeps the latched mode.
            r_s       <= '0;
            r_hit     <= '0;
            r_seq_ptr <= '0;
            r_trigger <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_s       <= w_s_n;
            r_hit     <= w_hit_n;
            r_seq_ptr <= w_ptr_n;
            r_trigger <= (w_state_n == ST_FIRED);
            r_pulse   <= w_fire;
        end
    end

    assign hit        = r_hit;
    assign seq_ptr    = r_seq_ptr;
    assign trigger    = r_trigger;
    assign trig_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_trotrig_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_trotrig_mc
// Brief    : Directed self-checking bench for trotrig_mc (three parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trotrig_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // u_a: 3 channels, 8-bit data, T = 4096
    logic        a_reset, a_clear;
    logic [2:0]  a_en;
    logic [23:0] a_din;
    logic [1:0]  a_mode;
    logic [2:0]  a_hit, a_ptr;
    logic        a_trig, a_pulse;

    // u_b: 2 channels, 8-bit data, T = 4096
    logic        b_reset, b_clear;
    logic [1:0]  b_en;
    logic [15:0] b_din;
    logic [1:0]  b_mode;
    logic [1:0]  b_hit;
    logic [2:0]  b_ptr;
    logic        b_trig, b_pulse;

    // u_c: 1 channel, 16-bit data, T = 2^20
    logic        c_reset, c_clear;
    logic [0:0]  c_en;
    logic [15:0] c_din;
    logic [1:0]  c_mode;
    logic [0:0]  c_hit;
    logic [2:0]  c_ptr;
    logic        c_trig, c_pulse;

    trotrig_mc #(.NCHAN(3), .DINBITS(8), .COUNTBITS(4)) u_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .enable(a_en), .din(a_din),
        .mode(a_mode), .hit(a_hit), .seq_ptr(a_ptr), .trigger(a_trig), .trig_pulse(a_pulse)
    );

    trotrig_mc #(.NCHAN(2), .DINBITS(8), .COUNTBITS(4)) u_b (
        .clk(clk), .reset(b_reset), .clear(b_clear), .enable(b_en), .din(b_din),
        .mode(b_mode), .hit(b_hit), .seq_ptr(b_ptr), .trigger(b_trig), .trig_pulse(b_pulse)
    );

    trotrig_mc #(.NCHAN(1), .DINBITS(16), .COUNTBITS(4)) u_c (
        .clk(clk), .reset(c_reset), .clear(c_clear), .enable(c_en), .din(c_din),
        .mode(c_mode), .hit(c_hit), .seq_ptr(c_ptr), .trigger(c_trig), .trig_pulse(c_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] ref_scr(input logic [31:0] v);
        logic [15:0] lo;
        lo = {v[15:8] ^ v[7:0], v[7:0]};
        return {v[31:16] ^ lo, lo};
    endfunction

    task automatic a_clear_to(input logic [1:0] m);
        a_clear = 1'b1; a_mode = m; a_en = 3'b111; a_din = '1;
        tick(1);
        a_clear = 1'b0; a_mode = 2'd0; a_en = 3'b000;
    endtask

    initial begin
        a_reset = 1'b1; a_clear = 1'b0; a_en = '0; a_din = '0; a_mode = 2'd0;
        b_reset = 1'b1; b_clear = 1'b0; b_en = '0; b_din = '0; b_mode = 2'd1;
        c_reset = 1'b1; c_clear = 1'b0; c_en = '0; c_din = '0; c_mode = 2'd0;
        tick(1);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        b_mode = 2'd0;
        check("rst_a_hit", a_hit, 0);
        check("rst_a_trig", a_trig, 0);
        check("rst_a_pulse", a_pulse, 0);
        check("rst_a_ptr", a_ptr, 0);
        check("rst_b_trig", b_trig, 0);
        check("rst_c_hit", c_hit, 0);

        // ANY: v = 256n crosses 4096 on the 17th enabled cycle
        a_en = 3'b001; a_din = 24'h0;
        tick(16);
        check("any_hit_16", a_hit, 3'b000);
        check("any_trig_16", a_trig, 0);
        tick(1);
        check("any_hit_17", a_hit, 3'b001);
        check("any_trig_17", a_trig, 1);
        check("any_pulse_17", a_pulse, 1);
        tick(1);
        check("any_pulse_18", a_pulse, 0);
        check("any_trig_18", a_trig, 1);

        // Reset while FIRED with every channel enabled
        a_reset = 1'b1; a_en = 3'b111; a_din = '1;
        tick(1);
        a_reset = 1'b0; a_en = 3'b000;
        check("prio_hit", a_hit, 0);
        check("prio_trig", a_trig, 0);
        check("prio_pulse", a_pulse, 0);
        check("prio_ptr", a_ptr, 0);

        // Clear latches ALL; the pin returns to ANY and must be ignored
        a_clear_to(2'd1);
        a_en = 3'b001; a_din = 24'h0000FF;
        tick(9);
        check("all_a_hit_ch0", a_hit, 3'b001);
        check("all_a_trig_ch0", a_trig, 0);
        a_en = 3'b110; a_din = 24'hFFFF00;
        tick(8);
        check("all_a_trig_8", a_trig, 0);
        tick(1);
        check("all_a_hit", a_hit, 3'b111);
        check("all_a_trig", a_trig, 1);
        check("all_a_pulse", a_pulse, 1);

        // SEQ in order 0,1,2 (din=255 crosses on the 9th enabled cycle)
        a_clear_to(2'd2);
        check("clr_hit", a_hit, 0);
        check("clr_trig", a_trig, 0);
        a_din = 24'hFFFFFF;
        a_en = 3'b001; tick(9);
        check("seq_hit0", a_hit, 3'b001);
        check("seq_ptr1", a_ptr, 1);
        check("seq_trig0", a_trig, 0);
        a_en = 3'b010; tick(9);
        check("seq_hit1", a_hit, 3'b011);
        check("seq_ptr2", a_ptr, 2);
        a_en = 3'b100; tick(8);
        check("seq_trig_8", a_trig, 0);
        tick(1);
        check("seq_hit2", a_hit, 3'b111);
        check("seq_trig", a_trig, 1);
        check("seq_pulse", a_pulse, 1);
        check("seq_ptr_fired", a_ptr, 2);
        tick(1);
        check("seq_pulse_off", a_pulse, 0);
        check("seq_ptr_hold", a_ptr, 2);

        // SEQ out of order: channel 1 first disarms
        a_clear_to(2'd2);
        a_en = 3'b010; tick(9);
        check("ooo_hit", a_hit, 0);
        check("ooo_ptr", a_ptr, 0);
        check("ooo_trig", a_trig, 0);
        tick(8);
        check("ooo_acc_zeroed", a_hit, 0);
        a_en = 3'b001; tick(9);
        check("ooo_mode_kept_hit", a_hit, 3'b001);
        check("ooo_mode_kept_ptr", a_ptr, 1);

        // SEQ: channels 0 and 1 cross together
        a_clear_to(2'd2);
        a_en = 3'b011; tick(9);
        check("pair_ptr", a_ptr, 2);
        check("pair_hit", a_hit, 3'b011);
        check("pair_trig", a_trig, 0);
        a_en = 3'b000;

        // ALL on 2 channels: ch1 enabled from cycle 20, crosses on cycle 36
        b_din = 16'h00FF;
        for (int cyc = 1; cyc <= 37; cyc++) begin
            b_en = {(cyc >= 20), 1'b1};
            tick(1);
            if (cyc == 9) begin
                check("allb_hit_ch0", b_hit, 2'b01);
                check("allb_trig_ch0", b_trig, 0);
            end
            if (cyc == 35) check("allb_trig_35", b_trig, 0);
            if (cyc == 36) begin
                check("allb_hit_36", b_hit, 2'b11);
                check("allb_trig_36", b_trig, 1);
                check("allb_pulse_36", b_pulse, 1);
            end
            if (cyc == 37) check("allb_pulse_37", b_pulse, 0);
        end
        b_en = 2'b00;

        // Saturation: each step adds 0x1FFFF; step 32769 saturates
        c_en = 1'b1; c_din = 16'hFFFF;
        tick(8);
        check("sat_hit_8", c_hit, 0);
        tick(1);
        check("sat_hit_9", c_hit, 1);
        check("sat_trig_9", c_trig, 1);
        tick(32768 - 9);
        check("sat_pre", u_c.r_s[0], ref_scr(32'hFFFF_8000));
        tick(1);
        check("sat_top", u_c.r_s[0], ref_scr(32'hFFFF_FFFF));
        tick(5);
        check("sat_hold", u_c.r_s[0], ref_scr(32'hFFFF_FFFF));
        check("sat_hit_hold", c_hit, 1);
        check("sat_trig_hold", c_trig, 1);
        check("sat_pulse_low", c_pulse, 0);
        c_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trotrig_mc.md
# trotrig_mc

Multi-channel, mode-selectable trojan trigger: the parametrised successor to our single-channel trotrig. Each of NCHAN channels keeps a scrambled 32-bit accumulator that grows by `din + 2^DINBITS` on every enabled cycle and saturates instead of wrapping. A per-channel threshold crossing feeds a small arming FSM that fires in ANY, ALL or ordered-SEQUENCE mode. The block sits beside the datapath it watches and drives a registered, sticky trigger plus a one-cycle pulse.

## Interface
- NCHAN, 4, number of channels (1..8)
- DINBITS, 8, per-channel data width
- COUNTBITS, 20, threshold exponent offset; threshold T = 2^(DINBITS+COUNTBITS); DINBITS+COUNTBITS ≤ 30
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; one clock; highest priority
- clear  in  1  synchronous re-arm: zeroes accumulators and FSM; also latches mode
- enable  in  NCHAN  per-channel enable; bit i gates channel i
- din  in  NCHAN*DINBITS  channel i data at din[i*DINBITS +: DINBITS]
- mode  in  2  0=ANY, 1=ALL, 2=SEQ, 3=reserved (behaves as ANY); sampled only on reset/clear cycles
- hit  out  NCHAN  registered per-channel flag: descrambled accumulator > T
- seq_ptr  out  3  registered SEQ pointer (next channel expected); 0 in other modes
- trigger  out  1  registered, sticky fire flag
- trig_pulse  out  1  registered, high for exactly the first cycle trigger is high

## Operation
- Scrambling: stored word s = S(v). S: v[15:8] ^= v[7:0], then v[31:16] ^= v[15:0]. Descramble D reverses the order: s[31:16] ^= s[15:0], then s[15:8] ^= s[7:0]. Only s is held in flops; v never appears in a register.
- Channel update when enable[i]=1: v' = min(D(s) + din_i + 2^DINBITS, 2^32−1), computed with a 33-bit sum and saturation. With enable[i]=0, s is held. v is therefore monotonic non-decreasing.
- Crossing: cross[i] = (v'_i > T) && !hit[i]. Each channel crosses at most once between clears. Next hit[i] = v'_i > T.
- Priority: reset > clear > normal. Reset and clear both force all s to 0, hit, seq_ptr, trigger and trig_pulse to 0, FSM to ARMED, and mode_q <= mode.
- FSM states: ARMED and FIRED. FIRED is left only on reset or clear. While FIRED, accumulators and hit keep updating; trigger stays 1.
- ANY: ARMED→FIRED when any next hit bit is 1.
- ALL: ARMED→FIRED when all NCHAN next hit bits are 1. Crossings may occur in any order or cycle.
- SEQ: let r = length of the contiguous run of cross bits starting at seq_ptr.
  - No crossings: hold.
  - Every set cross bit lies inside that run: seq_ptr += r; if seq_ptr+r == NCHAN, go to FIRED.
  - Any set cross bit lies outside the run (out of order): disarm. Treated exactly as clear for all channels that cycle (s, hit, seq_ptr to 0), but mode_q is kept.
- Once FIRED in SEQ, seq_ptr holds NCHAN−1's successor value clipped to NCHAN−1.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: an enabled cycle t whose v' crosses T gives hit[i]=1 at t+1. If that crossing satisfies the mode, trigger=1 and trig_pulse=1 also at t+1, and trig_pulse=0 at t+2.
- clear asserted at t: all outputs are 0 at t+1, and the new mode is effective for cycle t+1's updates.
- Enable together with clear/reset: the enable is ignored.
- Mode pin changes between reset/clear cycles have no effect.
- Saturation: an accumulator at 2^32−1 stays there. No wrap-around ever clears hit.

## Test plan
- ANY, DINBITS=8, COUNTBITS=4 (T=4096), ch0 enabled every cycle with din=0 → v=256n. hit[0], trigger and trig_pulse rise after the 17th enabled cycle; trig_pulse lasts 1 cycle.
- ALL, NCHAN=2: ch0 din=255 every cycle (crosses after the 9th) and ch1 enabled only from cycle 20 with din=0 → trigger rises exactly 1 cycle after ch1's 17th enabled cycle, not after ch0's crossing.
- SEQ, NCHAN=3, channels crossing in order 0,1,2 on separate cycles → seq_ptr goes 1, 2, then trigger=1. Order 1 before 0 → disarm: hit=0, seq_ptr=0, trigger stays 0.
- SEQ: channels 0 and 1 cross in the same cycle with seq_ptr=0 → seq_ptr=2 next cycle, no disarm.
- Saturation: preload v near 2^32−1 via a long run with DINBITS=16, din=16'hFFFF → v reaches 2^32−1 and holds, and hit stays 1.
- Priority: assert reset while FIRED with enable all-ones → next cycle all outputs 0. Then assert clear with mode=1 while the mode pin had been 0 → ALL semantics apply afterwards.
